// File: rtl/fifo_32i_16o_pkg.sv
// -----------------------------------------------------------------------------
// fifo_32i_16o_pkg
// Shared constants and helpers for the 32-bit-in / 16-bit-out synchronous FIFO.
//   WR_W  : write word width (32)
//   RD_W  : read half width (16)
//   RATIO : halves per word (2)
//   ptr_w : pointer width for a given ADDR_W (one wrap bit above the address)
// -----------------------------------------------------------------------------
package fifo_32i_16o_pkg;

   localparam int WR_W  = 32;
   localparam int RD_W  = 16;
   localparam int RATIO = 2;

   // Pointer width carries one extra MSB so full and empty can be told apart.
   function automatic int ptr_w(input int addr_w);
      return addr_w + 32'sd1;
   endfunction

endpackage

// File: rtl/fifo_32i_16o_if.sv
// -----------------------------------------------------------------------------
// fifo_32i_16o_if
// Bus bundle for fifo_32i_16o_sync.
//   write side : wr_data, wr_en -> ; <- wr_full, almost_full, wr_water_level
//   read side  : rd_en -> ; <- rd_data, rd_empty, almost_empty, rd_water_level
//   optional   : overflow, underflow (only with FIFO_32I_16O_STICKY_ERR_EN)
// Modports: master (producer/consumer side), slave (the FIFO).
// -----------------------------------------------------------------------------
interface fifo_32i_16o_if
   import fifo_32i_16o_pkg::*;
#(
   parameter int ADDR_W = 9
) ();

   logic [WR_W-1:0]   wr_data;
   logic              wr_en;
   logic              wr_full;
   logic              almost_full;
   logic [ADDR_W:0]   wr_water_level;
   logic [RD_W-1:0]   rd_data;
   logic              rd_en;
   logic              rd_empty;
   logic              almost_empty;
   logic [ADDR_W+1:0] rd_water_level;
`ifdef FIFO_32I_16O_STICKY_ERR_EN
   logic              overflow;
   logic              underflow;
`endif

   modport master (
      output wr_data, wr_en, rd_en,
`ifdef FIFO_32I_16O_STICKY_ERR_EN
      input  overflow, underflow,
`endif
      input  wr_full, almost_full, wr_water_level,
      input  rd_data, rd_empty, almost_empty, rd_water_level
   );

   modport slave (
      input  wr_data, wr_en, rd_en,
`ifdef FIFO_32I_16O_STICKY_ERR_EN
      output overflow, underflow,
`endif
      output wr_full, almost_full, wr_water_level,
      output rd_data, rd_empty, almost_empty, rd_water_level
   );

endinterface

// File: rtl/fifo_32i_16o_sdp_ram.sv
// -----------------------------------------------------------------------------
// fifo_32i_16o_sdp_ram
// Simple dual-port RAM, 2**ADDR_W x DATA_W, one clock.
//   clk_i, rst_ni          : clock, async active-low reset (read register only)
//   we_i, waddr_i, wdata_i : write port
//   re_i, raddr_i, rdata_o : synchronous read port; rdata_o holds when re_i=0
// Array contents are not reset.
// -----------------------------------------------------------------------------
module fifo_32i_16o_sdp_ram #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];
   logic [DATA_W-1:0] rdata_q;

   // Storage array write port.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Read data register; reset so the FIFO output starts at zero.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdata_q <= {DATA_W{1'b0}};
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_32i_16o_sync.sv
// -----------------------------------------------------------------------------
// fifo_32i_16o_sync
// Single-clock width-down FIFO: 32-bit words in, 16-bit halves out
// (bits [15:0] first, then [31:16]). One-cycle read latency from the RAM
// read register, no extra output stage.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fifo_32i_16o_if.slave (write/read handshakes and status)
// Optional macro FIFO_32I_16O_STICKY_ERR_EN adds sticky overflow/underflow.
// All status outputs are registered next-state values of the pointers.
// -----------------------------------------------------------------------------
module fifo_32i_16o_sync
   import fifo_32i_16o_pkg::*;
#(
   parameter int ADDR_W           = 9,
   parameter int ALMOST_FULL_NUM  = 508,
   parameter int ALMOST_EMPTY_NUM = 4
) (
   input logic           clk,
   input logic           rst_n,
   fifo_32i_16o_if.slave bus
);

   localparam int            PW      = ptr_w(ADDR_W);
   localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};
   localparam logic [PW-1:0] AF_TH   = PW'(ALMOST_FULL_NUM);
   localparam logic [PW:0]   AE_TH   = (PW+1)'(ALMOST_EMPTY_NUM);
   localparam logic          AF_RST  = (ALMOST_FULL_NUM == 0) ? 1'b1 : 1'b0;

   // Full when the wrap bits differ and the word addresses match.
   function automatic logic is_full(input logic [PW-1:0] w, input logic [PW-1:0] r);
      return (w[PW-1] != r[PW-1]) && (w[PW-2:0] == r[PW-2:0]);
   endfunction

   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic            hsel_q, hsel_d;
   logic            hsel_rd_q;
   logic            wr_full_q, almost_full_q;
   logic            rd_empty_q, almost_empty_q;
   logic [PW-1:0]   wr_lvl_q, wr_lvl_d;
   logic [PW:0]     rd_lvl_q, rd_lvl_d;
   logic            wr_accept_s, rd_accept_s;
   logic [WR_W-1:0] rdata_s;

   // Accept decisions and next pointer/level values.
   always_comb begin
      wr_accept_s = bus.wr_en && !wr_full_q;
      rd_accept_s = bus.rd_en && !rd_empty_q;

      if (wr_accept_s) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (rd_accept_s) begin
         hsel_d = ~hsel_q;
      end else begin
         hsel_d = hsel_q;
      end

      // The word is released only once its upper half has been read.
      if (rd_accept_s && hsel_q) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      wr_lvl_d = wr_ptr_d - rd_ptr_d;
      rd_lvl_d = ((PW+1)'(wr_lvl_d) * (PW+1)'(RATIO)) - {{PW{1'b0}}, hsel_d};
   end

   // Pointer, half-select and registered status state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q       <= {PW{1'b0}};
         rd_ptr_q       <= {PW{1'b0}};
         hsel_q         <= 1'b0;
         hsel_rd_q      <= 1'b0;
         wr_full_q      <= 1'b0;
         almost_full_q  <= AF_RST;
         rd_empty_q     <= 1'b1;
         almost_empty_q <= 1'b1;
         wr_lvl_q       <= {PW{1'b0}};
         rd_lvl_q       <= {(PW+1){1'b0}};
      end else begin
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         hsel_q         <= hsel_d;
         // Half-select copy aligned with the RAM read register.
         if (rd_accept_s) begin
            hsel_rd_q   <= hsel_q;
         end
         wr_full_q      <= is_full(wr_ptr_d, rd_ptr_d);
         almost_full_q  <= (wr_lvl_d >= AF_TH);
         rd_empty_q     <= (rd_lvl_d == {(PW+1){1'b0}});
         almost_empty_q <= (rd_lvl_d <= AE_TH);
         wr_lvl_q       <= wr_lvl_d;
         rd_lvl_q       <= rd_lvl_d;
      end
   end

`ifdef FIFO_32I_16O_STICKY_ERR_EN
   logic overflow_q, underflow_q;

   // Sticky flags for requests dropped against full/empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (bus.wr_en && wr_full_q) begin
            overflow_q <= 1'b1;
         end
         if (bus.rd_en && rd_empty_q) begin
            underflow_q <= 1'b1;
         end
      end
   end

   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;
`endif

   fifo_32i_16o_sdp_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (WR_W)
   ) u_ram (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .we_i    (wr_accept_s),
      .waddr_i (wr_ptr_q[ADDR_W-1:0]),
      .wdata_i (bus.wr_data),
      .re_i    (rd_accept_s),
      .raddr_i (rd_ptr_q[ADDR_W-1:0]),
      .rdata_o (rdata_s)
   );

   assign bus.rd_data        = hsel_rd_q ? rdata_s[WR_W-1:RD_W] : rdata_s[RD_W-1:0];
   assign bus.wr_full        = wr_full_q;
   assign bus.almost_full    = almost_full_q;
   assign bus.wr_water_level = wr_lvl_q;
   assign bus.rd_empty       = rd_empty_q;
   assign bus.almost_empty   = almost_empty_q;
   assign bus.rd_water_level = rd_lvl_q;

endmodule

// File: tb/tb_fifo_32i_16o_sync.sv
// -----------------------------------------------------------------------------
// tb_fifo_32i_16o_sync
// Directed bench for fifo_32i_16o_sync with ADDR_W=4, ALMOST_FULL_NUM=14,
// ALMOST_EMPTY_NUM=2. Inputs change 1 ns after a rising edge and outputs are
// sampled at the same point, so each check sees the post-edge state.
// -----------------------------------------------------------------------------
module tb_fifo_32i_16o_sync;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   fifo_32i_16o_if #(.ADDR_W(4)) bus ();

   fifo_32i_16o_sync #(
      .ADDR_W           (4),
      .ALMOST_FULL_NUM  (14),
      .ALMOST_EMPTY_NUM (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.wr_data = 32'h0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #3;
      total++; if (bus.rd_empty !== 1'b1) begin bad++; $display("FAIL reset_rd_empty got=%0b exp=1", bus.rd_empty); end
      total++; if (bus.wr_full !== 1'b0) begin bad++; $display("FAIL reset_wr_full got=%0b exp=0", bus.wr_full); end
      total++; if (bus.almost_full !== 1'b0) begin bad++; $display("FAIL reset_almost_full got=%0b exp=0", bus.almost_full); end
      total++; if (bus.almost_empty !== 1'b1) begin bad++; $display("FAIL reset_almost_empty got=%0b exp=1", bus.almost_empty); end
      total++; if (bus.wr_water_level !== 5'd0) begin bad++; $display("FAIL reset_wr_lvl got=%0d exp=0", bus.wr_water_level); end
      total++; if (bus.rd_water_level !== 6'd0) begin bad++; $display("FAIL reset_rd_lvl got=%0d exp=0", bus.rd_water_level); end
      total++; if (bus.rd_data !== 16'h0000) begin bad++; $display("FAIL reset_rd_data got=%h exp=0000", bus.rd_data); end
`ifdef FIFO_32I_16O_STICKY_ERR_EN
      total++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin bad++; $display("FAIL reset_sticky got=%0b%0b exp=00", bus.overflow, bus.underflow); end
`endif
      @(posedge clk);
      #1 rst_n = 1'b1;
      step();
   endtask

   task automatic test_single();
      bus.wr_data = 32'hBBBB_AAAA; bus.wr_en = 1'b1;
      step();
      bus.wr_en = 1'b0;
      total++; if (bus.rd_water_level !== 6'd2 || bus.wr_water_level !== 5'd1) begin bad++; $display("FAIL single_lvl got=%0d/%0d exp=2/1", bus.rd_water_level, bus.wr_water_level); end
      total++; if (bus.rd_empty !== 1'b0) begin bad++; $display("FAIL single_not_empty got=%0b exp=0", bus.rd_empty); end
      bus.rd_en = 1'b1;
      step();
      total++; if (bus.rd_data !== 16'hAAAA) begin bad++; $display("FAIL single_lo got=%h exp=AAAA", bus.rd_data); end
      total++; if (bus.rd_water_level !== 6'd1 || bus.wr_water_level !== 5'd1) begin bad++; $display("FAIL single_mid_lvl got=%0d/%0d exp=1/1", bus.rd_water_level, bus.wr_water_level); end
      step();
      bus.rd_en = 1'b0;
      total++; if (bus.rd_data !== 16'hBBBB) begin bad++; $display("FAIL single_hi got=%h exp=BBBB", bus.rd_data); end
      total++; if (bus.rd_empty !== 1'b1) begin bad++; $display("FAIL single_empty got=%0b exp=1", bus.rd_empty); end
      total++; if (bus.rd_water_level !== 6'd0 || bus.wr_water_level !== 5'd0) begin bad++; $display("FAIL single_end_lvl got=%0d/%0d exp=0/0", bus.rd_water_level, bus.wr_water_level); end
   endtask

   task automatic test_fill();
      logic [15:0] v;
      for (int i = 0; i < 16; i++) begin
         v = 16'(i);
         bus.wr_data = {v, v}; bus.wr_en = 1'b1;
         step();
         total++; if (bus.almost_full !== ((i + 1) >= 14)) begin bad++; $display("FAIL fill_af[%0d] got=%0b exp=%0b", i, bus.almost_full, ((i + 1) >= 14)); end
         total++; if (bus.wr_full !== (i == 15)) begin bad++; $display("FAIL fill_full[%0d] got=%0b exp=%0b", i, bus.wr_full, (i == 15)); end
      end
`ifdef FIFO_32I_16O_STICKY_ERR_EN
      total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL fill_ovf_pre got=%0b exp=0", bus.overflow); end
`endif
      bus.wr_data = 32'hDEAD_BEEF;
      step();
      bus.wr_en = 1'b0;
      total++; if (bus.wr_full !== 1'b1) begin bad++; $display("FAIL fill_drop_full got=%0b exp=1", bus.wr_full); end
      total++; if (bus.rd_water_level !== 6'd32 || bus.wr_water_level !== 5'd16) begin bad++; $display("FAIL fill_drop_lvl got=%0d/%0d exp=32/16", bus.rd_water_level, bus.wr_water_level); end
      total++; if (bus.almost_empty !== 1'b0) begin bad++; $display("FAIL fill_ae got=%0b exp=0", bus.almost_empty); end
`ifdef FIFO_32I_16O_STICKY_ERR_EN
      total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL fill_ovf got=%0b exp=1", bus.overflow); end
`endif
   endtask

   task automatic test_drain();
      int rel;
      bus.rd_en = 1'b1;
      for (int n = 0; n < 32; n++) begin
         step();
         rel = (n + 1) / 2;
         total++; if (bus.rd_data !== 16'(n / 2)) begin bad++; $display("FAIL drain_data[%0d] got=%h exp=%h", n, bus.rd_data, 16'(n / 2)); end
         total++; if (bus.rd_water_level !== 6'(31 - n) || bus.wr_water_level !== 5'(16 - rel)) begin bad++; $display("FAIL drain_lvl[%0d] got=%0d/%0d exp=%0d/%0d", n, bus.rd_water_level, bus.wr_water_level, 31 - n, 16 - rel); end
         total++; if (bus.wr_full !== (rel == 0)) begin bad++; $display("FAIL drain_full[%0d] got=%0b exp=%0b", n, bus.wr_full, (rel == 0)); end
         total++; if (bus.almost_empty !== ((31 - n) <= 2)) begin bad++; $display("FAIL drain_ae[%0d] got=%0b exp=%0b", n, bus.almost_empty, ((31 - n) <= 2)); end
      end
      bus.rd_en = 1'b0;
      total++; if (bus.rd_empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%0b exp=1", bus.rd_empty); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp_q[$];
      logic [15:0] exp_v;
      logic [15:0] lo;
      logic        do_rd;
      int          wsent;
      int          rcnt;
      int          cyc;
      wsent = 0; rcnt = 0; cyc = 0;
      while ((wsent < 100 || exp_q.size() > 0) && cyc < 1000) begin
         do_rd = (exp_q.size() > 0);
         lo = 16'h5000 + 16'(2 * wsent);
         bus.wr_en = (wsent < 100) && (cyc % 2 == 0);
         bus.wr_data = {lo + 16'h0001, lo};
         bus.rd_en = do_rd;
         step();
         exp_v = 16'h0;
         if (do_rd) begin
            exp_v = exp_q.pop_front();
            rcnt++;
         end
         if (bus.wr_en) begin
            exp_q.push_back(lo);
            exp_q.push_back(lo + 16'h0001);
            wsent++;
         end
         if (do_rd) begin
            total++; if (bus.rd_data !== exp_v) begin bad++; $display("FAIL stream_data[%0d] got=%h exp=%h", rcnt, bus.rd_data, exp_v); end
         end
         total++; if (bus.rd_water_level !== 6'(exp_q.size())) begin bad++; $display("FAIL stream_lvl[%0d] got=%0d exp=%0d", cyc, bus.rd_water_level, exp_q.size()); end
         cyc++;
      end
      bus.wr_en = 1'b0; bus.rd_en = 1'b0;
      total++; if (rcnt != 200) begin bad++; $display("FAIL stream_count got=%0d exp=200", rcnt); end
      total++; if (bus.rd_empty !== 1'b1) begin bad++; $display("FAIL stream_empty got=%0b exp=1", bus.rd_empty); end
   endtask

   task automatic test_underflow();
      bus.wr_data = 32'h1234_5678; bus.wr_en = 1'b1;
      step();
      bus.wr_en = 1'b0; bus.rd_en = 1'b1;
      step();
      total++; if (bus.rd_data !== 16'h5678) begin bad++; $display("FAIL uf_lo got=%h exp=5678", bus.rd_data); end
`ifdef FIFO_32I_16O_STICKY_ERR_EN
      total++; if (bus.underflow !== 1'b0) begin bad++; $display("FAIL uf_pre got=%0b exp=0", bus.underflow); end
`endif
      step();
      total++; if (bus.rd_data !== 16'h1234) begin bad++; $display("FAIL uf_hi got=%h exp=1234", bus.rd_data); end
      for (int k = 0; k < 3; k++) begin
         step();
         total++; if (bus.rd_data !== 16'h1234) begin bad++; $display("FAIL uf_hold[%0d] got=%h exp=1234", k, bus.rd_data); end
         total++; if (bus.rd_empty !== 1'b1 || bus.rd_water_level !== 6'd0) begin bad++; $display("FAIL uf_empty[%0d] got=%0b/%0d exp=1/0", k, bus.rd_empty, bus.rd_water_level); end
      end
      bus.rd_en = 1'b0;
      step();
`ifdef FIFO_32I_16O_STICKY_ERR_EN
      total++; if (bus.underflow !== 1'b1) begin bad++; $display("FAIL uf_sticky got=%0b exp=1", bus.underflow); end
`endif
      total++; if (bus.rd_data !== 16'h1234) begin bad++; $display("FAIL uf_idle_hold got=%h exp=1234", bus.rd_data); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 6; i++) begin
         bus.wr_data = {16'hA100 + 16'(i), 16'hB100 + 16'(i)}; bus.wr_en = 1'b1;
         step();
      end
      bus.wr_en = 1'b0; bus.rd_en = 1'b1;
      step();
      step();
      bus.rd_en = 1'b0;
      total++; if (bus.rd_data !== 16'hA100) begin bad++; $display("FAIL rm_pre_data got=%h exp=A100", bus.rd_data); end
      total++; if (bus.wr_water_level !== 5'd5) begin bad++; $display("FAIL rm_pre_lvl got=%0d exp=5", bus.wr_water_level); end
      bus.wr_data = 32'h7777_7777; bus.wr_en = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      total++; if (bus.rd_empty !== 1'b1 || bus.wr_full !== 1'b0) begin bad++; $display("FAIL rm_flags got=%0b/%0b exp=1/0", bus.rd_empty, bus.wr_full); end
      total++; if (bus.rd_water_level !== 6'd0 || bus.wr_water_level !== 5'd0) begin bad++; $display("FAIL rm_lvl got=%0d/%0d exp=0/0", bus.rd_water_level, bus.wr_water_level); end
      total++; if (bus.rd_data !== 16'h0000) begin bad++; $display("FAIL rm_rd_data got=%h exp=0000", bus.rd_data); end
`ifdef FIFO_32I_16O_STICKY_ERR_EN
      total++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin bad++; $display("FAIL rm_sticky got=%0b%0b exp=00", bus.overflow, bus.underflow); end
`endif
      bus.wr_en = 1'b0;
      #2 rst_n = 1'b1;
      step();
      bus.wr_data = 32'hCAFE_F00D; bus.wr_en = 1'b1;
      step();
      bus.wr_en = 1'b0;
      total++; if (bus.wr_water_level !== 5'd1 || bus.rd_water_level !== 6'd2) begin bad++; $display("FAIL rm_post_lvl got=%0d/%0d exp=1/2", bus.wr_water_level, bus.rd_water_level); end
      bus.rd_en = 1'b1;
      step();
      total++; if (bus.rd_data !== 16'hF00D) begin bad++; $display("FAIL rm_post_lo got=%h exp=F00D", bus.rd_data); end
      step();
      bus.rd_en = 1'b0;
      total++; if (bus.rd_data !== 16'hCAFE) begin bad++; $display("FAIL rm_post_hi got=%h exp=CAFE", bus.rd_data); end
      total++; if (bus.rd_empty !== 1'b1) begin bad++; $display("FAIL rm_post_empty got=%0b exp=1", bus.rd_empty); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_single();
      test_fill();
      test_drain();
      test_back_to_back();
      test_underflow();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fifo_32i_16o_sync.md
Name: fifo_32i_16o_sync

Overview:
Synchronous width-down FIFO: 32-bit words are written in and 16-bit halves are read out. It is the counterpart of the 16-in/32-out capture FIFO, used on the playback/output path where packed 32-bit words must be drained as 16-bit samples. There is a single clock domain. Storage is an inferred simple-dual-port RAM. Read latency is one cycle, with no output register.

Parameters:
ADDR_W, 9, log2 of storage depth in 32-bit words (depth = 2**ADDR_W)
ALMOST_FULL_NUM, 508, wr_water_level threshold (in words) at or above which almost_full asserts
ALMOST_EMPTY_NUM, 4, rd_water_level threshold (in halves) at or below which almost_empty asserts

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
wr_data  in  32  write word; bits [15:0] are read out first, then bits [31:16]
wr_en  in  1  write request
wr_full  out  1  no free word slot
almost_full  out  1  wr_water_level >= ALMOST_FULL_NUM
wr_water_level  out  ADDR_W+1  occupied words, including a partially read word
rd_data  out  16  read half, valid the cycle after an accepted rd_en
rd_en  in  1  read request
rd_empty  out  1  no unread half
almost_empty  out  1  rd_water_level <= ALMOST_EMPTY_NUM
rd_water_level  out  ADDR_W+2  unread halves

Behaviour:
- Reset (rst_n low, asynchronous):
  - wr_ptr, rd_ptr and the half-select bit (hsel) clear to 0.
  - rd_data = 16'h0000.
  - wr_full = 0, almost_full = 0 (unless ALMOST_FULL_NUM = 0), rd_empty = 1, almost_empty = 1.
  - Both water levels = 0.
  - RAM contents are not reset.
- Pointers:
  - wr_ptr and rd_ptr are ADDR_W+1 bits; the extra MSB is the wrap bit.
  - Full: MSBs differ and the lower bits are equal.
  - Word empty: the pointers are equal.
- Write accept: wr_en && !wr_full. Writes mem[wr_ptr] and increments wr_ptr. A write while full is dropped silently; no state changes.
- Read accept: rd_en && !rd_empty.
  - Next cycle, rd_data = hsel ? mem[rd_ptr][31:16] : mem[rd_ptr][15:0].
  - hsel toggles on each accept.
  - rd_ptr increments only when an accepted read has hsel = 1, i.e. the word is released after its upper half.
- Read while empty: ignored; rd_data holds its last value.
- Derived quantities:
  - rd_water_level = 2*(wr_ptr - rd_ptr) - hsel, using modulo ADDR_W+1 arithmetic.
  - rd_empty = (rd_water_level == 0).
  - wr_water_level = wr_ptr - rd_ptr.
- All status outputs are registered. They reflect the state after the current edge's accepts and are valid in the following cycle.
- Simultaneous accepted write and read:
  - Both take effect.
  - When full, a same-cycle read does not admit a write; wr_full is evaluated pre-edge.
  - Writing to the slot being read is impossible because the full check prevents it.
- Read-during-write to the same address when word-empty does not occur, since rd_empty blocks the read.
- Wrap-around: both pointers roll over naturally through 2**(ADDR_W+1).
- Reset mid-operation: all in-flight data is discarded and state returns to the reset values immediately.

Optional Feature:
FIFO_32I_16O_STICKY_ERR_EN. When defined:
- Two extra outputs are added: overflow (1) and underflow (1), both reset to 0.
- overflow sets when wr_en && wr_full; underflow sets when rd_en && rd_empty.
- Both are sticky until reset.

When undefined, these ports and their logic do not exist, and dropped requests are silent.

Decomposition:
- Package fifo_32i_16o_pkg:
  - WR_W = 32, RD_W = 16.
  - A ratio constant of 2.
  - A pointer-type width function of ADDR_W.
- One sub-module, fifo_32i_16o_sdp_ram:
  - 2**ADDR_W x 32.
  - Write port: we, waddr, wdata.
  - Synchronous read port: re, raddr, rdata.
  - The top selects the half with a registered hsel copy.

Test Plan (ADDR_W = 4 override, ALMOST_FULL_NUM = 14, ALMOST_EMPTY_NUM = 2):
- Write 32'hBBBB_AAAA, then read 2 -> rd_data = 16'hAAAA then 16'hBBBB; rd_empty returns to 1, water levels return to 0.
- Write 16 words 32'h0000_0000..32'h000F_000F (value i in both halves).
  - wr_full = 1 after the 16th write; almost_full from the 14th.
  - A 17th write is dropped; rd_water_level = 32.
- From full, read 1 half -> wr_full stays 1 (word not released). Read a 2nd half -> wr_full = 0, wr_water_level = 15.
- Simultaneous write and read streaming 100 words with the pointers wrapping -> output sequence matches the low/high order exactly, with no gaps or duplicates.
- rd_en while empty, after the last half 16'h1234 -> rd_data holds 16'h1234. With FIFO_32I_16O_STICKY_ERR_EN defined, underflow = 1 and stays 1.
- Assert rst_n low mid-stream with 5 words buffered -> rd_empty = 1, wr_full = 0, both levels = 0, rd_data = 0 asynchronously. A subsequent write/read works from slot 0.
